// File: rtl/c7_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : c7_product_accumulator
//  Purpose  : Accumulates a programmable batch of 8-bit multiplier products.
//             Each finished sum is returned as two bytes, low then high.
//             The high byte carries the sticky overflow flag in bit 7.
//  Options  : C7_ACC_SATURATE_EN - when defined, the accumulator clamps at
//             2^ACC_W-1 on overflow; otherwise it wraps modulo 2^ACC_W.
//  Revision : 1.0 - initial release
// ============================================================================
module c7_product_accumulator #(
   parameter int ACC_W = 12,   // legal range 9..15
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [LEN_W-1:0] batch_len,
   input  logic             prod_valid,
   input  logic [7:0]       prod,
   output logic             prod_ready,
   output logic             res_valid,
   output logic [7:0]       res_data,
   output logic             res_last,
   input  logic             res_ready,
   output logic             busy
);

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   typedef enum logic [1:0] {
      ACC     = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nx;
   logic [ACC_W:0]     sum;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   len_eff;
   logic [LEN_W-1:0]   len_m1;
   logic               ovf;
   logic               in_acc;
   logic               prod_hs;
   logic               batch_done;
   logic               hi_done;
   logic [7:0]         hi_byte;

   assign in_acc  = (state == ACC);
   assign prod_hs = prod_valid & in_acc;
   assign hi_done = (state == SEND_HI) & res_ready;

   // The batch length is taken live on the first product and from len_q after.
   // A length of 0 wraps to all-ones when decremented, which is exactly the
   // last index of a full 2^LEN_W batch, so no special case is needed.
   assign len_eff    = (cnt == '0) ? batch_len : len_q;
   assign len_m1     = len_eff - CNT_ONE;
   assign batch_done = prod_hs & (cnt == len_m1);

   // Sum is one bit wider than the accumulator so the carry flags overflow.
   assign sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};

`ifdef C7_ACC_SATURATE_EN
   assign acc_nx = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_nx = sum[ACC_W-1:0];
`endif

   assign busy = (state != ACC) | (cnt != '0);

   // High result byte: overflow flag on top, upper accumulator bits at bottom.
   always_comb begin
      hi_byte              = '0;
      hi_byte[ACC_W-9:0]   = acc[ACC_W-1:8];
      hi_byte[7]           = ovf;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACC;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and output decode; outputs depend on registered state only.
   always_comb begin
      state_nx   = state;
      prod_ready = 1'b0;
      res_valid  = 1'b0;
      res_data   = 8'h00;
      res_last   = 1'b0;
      case (state)
         ACC: begin
            prod_ready = 1'b1;
            if (batch_done) state_nx = SEND_LO;
         end
         SEND_LO: begin
            res_valid = 1'b1;
            res_data  = acc[7:0];
            if (res_ready) state_nx = SEND_HI;
         end
         SEND_HI: begin
            res_valid = 1'b1;
            res_last  = 1'b1;
            res_data  = hi_byte;
            if (res_ready) state_nx = ACC;
         end
         default: state_nx = ACC;
      endcase
      if (clear) state_nx = ACC;
   end

   // Accumulator, product counter, latched length and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
         ovf   <= 1'b0;
      end else if (clear) begin
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else if (prod_hs) begin
         acc <= acc_nx;
         cnt <= cnt + CNT_ONE;
         ovf <= ovf | sum[ACC_W];
         if (cnt == '0) len_q <= batch_len;
      end else if (hi_done) begin
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_c7_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c7_product_accumulator
//  Purpose  : Self-checking bench; one instance at ACC_W=12 and one at
//             ACC_W=9 share the stimulus, each with its own scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_c7_product_accumulator;

   localparam int LEN_W = 4;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             clear      = 1'b0;
   logic [LEN_W-1:0] batch_len  = '0;
   logic             prod_valid = 1'b0;
   logic [7:0]       prod       = 8'h00;
   logic             res_ready  = 1'b1;

   logic             prod_ready_a, res_valid_a, res_last_a, busy_a;
   logic [7:0]       res_data_a;
   logic             prod_ready_b, res_valid_b, res_last_b, busy_b;
   logic [7:0]       res_data_b;

   always #5 clk = ~clk;

   c7_product_accumulator #(.ACC_W(12), .LEN_W(LEN_W)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .batch_len(batch_len),
      .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_a),
      .res_valid(res_valid_a), .res_data(res_data_a), .res_last(res_last_a),
      .res_ready(res_ready), .busy(busy_a)
   );

   c7_product_accumulator #(.ACC_W(9), .LEN_W(LEN_W)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .batch_len(batch_len),
      .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_b),
      .res_valid(res_valid_b), .res_data(res_data_b), .res_last(res_last_b),
      .res_ready(res_ready), .busy(busy_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Scoreboards hold {last, byte} for each instance.
   logic [8:0] qa[$];
   logic [8:0] qb[$];
   logic [8:0] exp_a, exp_b;

   // Reference model state for the batch in progress.
   int m_acc_a = 0, m_ovf_a = 0;
   int m_acc_b = 0, m_ovf_b = 0;

   function automatic int model_add(input int a, input int w, input int p, inout int ovf);
      int s;
      s = a + p;
      if (s >= (1 << w)) begin
         ovf = 1;
`ifdef C7_ACC_SATURATE_EN
         s = (1 << w) - 1;
`else
         s = s - (1 << w);
`endif
      end
      return s;
   endfunction

   task automatic model_reset();
      m_acc_a = 0; m_ovf_a = 0;
      m_acc_b = 0; m_ovf_b = 0;
   endtask

   // Offer one product after 'gap' idle cycles and wait for its acceptance.
   task automatic add_prod(input int p, input int gap);
      int ok;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      prod_valid = 1'b1;
      prod       = p[7:0];
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (prod_ready_a) begin ok = 1; break; end
      end
      if (ok == 0) check("prod_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      m_acc_a = model_add(m_acc_a, 12, p, m_ovf_a);
      m_acc_b = model_add(m_acc_b, 9,  p, m_ovf_b);
   endtask

   // Batch complete: result must be valid right after the last acceptance.
   task automatic finish_batch();
      logic [7:0] hi_a, hi_b;
      hi_a = 8'((m_acc_a >> 8) | (m_ovf_a << 7));
      hi_b = 8'((m_acc_b >> 8) | (m_ovf_b << 7));
      qa.push_back({1'b0, m_acc_a[7:0]});
      qa.push_back({1'b1, hi_a});
      qb.push_back({1'b0, m_acc_b[7:0]});
      qb.push_back({1'b1, hi_b});
      check("res_valid_after_last", res_valid_a, 1);
      model_reset();
   endtask

   task automatic drain();
      int ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (qa.size() == 0 && qb.size() == 0) begin ok = 1; break; end
         @(negedge clk);
      end
      if (ok == 0) check("drain_timeout", 0, 1);
   endtask

   // Result monitor: a byte is consumed when valid and ready meet.
   always @(negedge clk) begin
      if (rst_n && res_valid_a && res_ready) begin
         if (qa.size() == 0) check("unexpected_res_a", {res_last_a, res_data_a}, 9'h1FF);
         else begin
            exp_a = qa.pop_front();
            check("res_a", {res_last_a, res_data_a}, exp_a);
         end
      end
      if (rst_n && res_valid_b && res_ready) begin
         if (qb.size() == 0) check("unexpected_res_b", {res_last_b, res_data_b}, 9'h1FF);
         else begin
            exp_b = qb.pop_front();
            check("res_b", {res_last_b, res_data_b}, exp_b);
         end
      end
   end

   // Hard stop in case the stimulus itself stalls.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_prod_ready", prod_ready_a, 1);
      check("rst_res_valid",  res_valid_a,  0);
      check("rst_res_data",   res_data_a,   8'h00);
      check("rst_res_last",   res_last_a,   0);
      check("rst_busy",       busy_a,       0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic batch 225+16+7 = 248, result held back for 5 cycles
      res_ready = 1'b0;
      batch_len = 4'd3;
      add_prod(225, 0);
      check("busy_mid_batch", busy_a, 1);
      add_prod(16, 0);
      add_prod(7, 0);
      finish_batch();
      repeat (5) begin
         @(negedge clk);
         check("hold_res_data",   res_data_a,   8'hF8);
         check("hold_prod_ready", prod_ready_a, 0);
         check("hold_res_last",   res_last_a,   0);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      drain();
      @(posedge clk);
      @(negedge clk);
      check("busy_after_hi", busy_a, 0);

      // Full-length batch with gaps on the product side: 16 x 225 = 3600
      @(posedge clk);
      #1;
      batch_len = 4'd0;
      for (int i = 0; i < 16; i++) add_prod(225, i % 2);
      finish_batch();
      drain();

      // Clear while the high byte is pending
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      batch_len = 4'd2;
      add_prod(1, 0);
      add_prod(2, 0);
      finish_batch();
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      clear     = 1'b1;
      @(negedge clk);
      check("in_send_hi", res_last_a, 1);
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("clear_res_valid", res_valid_a, 0);
      check("clear_busy",      busy_a,      0);
      check("dropped_pending", qa.size(),   1);
      qa.delete();
      qb.delete();
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      batch_len = 4'd1;
      add_prod(5, 0);
      finish_batch();
      drain();

      // Overflow batch: 3 x 225 = 675 (exceeds 511 on the 9-bit instance)
      @(posedge clk);
      #1;
      batch_len = 4'd3;
      for (int i = 0; i < 3; i++) add_prod(225, 0);
      finish_batch();
      drain();

      // Asynchronous reset mid-batch
      @(posedge clk);
      #1;
      batch_len = 4'd3;
      add_prod(100, 0);
      add_prod(50, 0);
      check("busy_before_reset", busy_a, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_prod_ready", prod_ready_a, 1);
      check("arst_res_valid",  res_valid_a,  0);
      check("arst_res_data",   res_data_a,   8'h00);
      check("arst_res_last",   res_last_a,   0);
      check("arst_busy",       busy_a,       0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      batch_len = 4'd1;
      add_prod(9, 0);
      finish_batch();
      drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/c7_product_accumulator.md
# c7_product_accumulator

Downstream stage of the 4x4 array multiplier: consumes its 8-bit products over a valid/ready handshake and sums a programmable batch of them into an accumulator. Each finished batch is returned as two bytes, low then high, over a second valid/ready handshake. The block sits between the multiplier output and the 8-bit `uo_out` pin group of the tile.

## Interface

- `ACC_W`, 12 — accumulator width in bits; legal range 9..15.
- `LEN_W`, 4 — width of `batch_len`.

- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `clear` in 1 — synchronous abort/clear; highest priority.
- `batch_len` in LEN_W — products per batch; 0 means 2^LEN_W; sampled on the first product of a batch.
- `prod_valid` in 1 — product available.
- `prod` in 8 — unsigned product from the multiplier.
- `prod_ready` out 1 — block accepts a product.
- `res_valid` out 1 — result byte available.
- `res_data` out 8 — result byte.
- `res_last` out 1 — high while the high byte is presented.
- `res_ready` in 1 — consumer takes the byte.
- `busy` out 1 — batch in progress or result pending.

## Operation

- States: ACC, SEND_LO, SEND_HI. Reset state is ACC.
- ACC:
  - `prod_ready` = 1.
  - On handshake (`prod_valid & prod_ready`): `acc <= acc + prod`, `cnt <= cnt + 1`.
  - `batch_len` is latched into `len_q` when `cnt == 0`.
  - When the handshake completes the batch (`cnt == len_q - 1`, or `len_q` = 2^LEN_W): go to SEND_LO, with the final sum included.
- SEND_LO:
  - `res_valid` = 1, `res_data` = `acc[7:0]`, `res_last` = 0.
  - On `res_ready`: go to SEND_HI.
- SEND_HI:
  - `res_valid` = 1, `res_last` = 1.
  - `res_data` = {`ovf`, zeros, `acc[ACC_W-1:8]`}.
  - On `res_ready`: go to ACC; `acc`, `cnt` and `ovf` are cleared.
- `prod_ready` = 0 in both SEND states; no product is accepted while a result is pending.
- Arithmetic:
  - Unsigned; the sum is formed at ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets sticky `ovf`, which is cleared only at the end of the batch, by `clear`, or by reset.
  - With the default ACC_W=12 and LEN_W=4, the worst case is 16×225 = 3600, so overflow cannot occur.
- `busy` = (state != ACC) | (`cnt != 0`).
- `clear`:
  - Sets state to ACC and clears `acc`, `cnt` and `ovf` on the next edge, from any state.
  - A pending result is dropped.
  - A product presented in the same cycle is accepted by the handshake but discarded.

## Timing

- Reset values: `prod_ready`=1, `res_valid`=0, `res_data`=0x00, `res_last`=0, `busy`=0.
- All outputs are decoded from registered state only; there is no combinational input→output path.
- Latency: the last product is accepted at edge k; `res_valid` is high after edge k; the low byte can be taken at edge k+1 at the earliest and the high byte at edge k+2.
- A new product is accepted at earliest in the cycle after the high-byte handshake, so a batch of N products takes at least N+2 cycles.
- `res_data` and `res_last` stay stable while `res_valid` is high and `res_ready` is low.
- Reset asserted mid-batch or mid-send returns all outputs to their reset values immediately.

## Configuration

- `C7_ACC_SATURATE_EN` defined: on overflow, `acc` clamps to 2^ACC_W−1 and stays there for the rest of the batch; `ovf` is set.
- Undefined: `acc` wraps modulo 2^ACC_W; `ovf` is set the same way.

## Test plan

- Basic batch: `batch_len`=3; products 225, 16, 7 with no stalls → bytes 0xF8 then 0x00 (with `res_last`=1); `busy` falls after the high-byte handshake.
- Full-length batch: `batch_len`=0; 16 products of 225 → bytes 0x10 then 0x0E; `ovf`=0.
- Backpressure:
  - Hold `res_ready`=0 for 5 cycles in SEND_LO → `res_data` stays 0xF8 and `prod_ready` stays 0.
  - Toggle `prod_valid` with gaps → the sum is unchanged.
- Clear: assert `clear` in SEND_HI → next cycle `res_valid`=0 and `busy`=0; the next batch (len 1, product 5) yields 0x05, 0x00.
- Overflow, ACC_W=9, `batch_len`=3, products 225×3:
  - With the macro → 511: bytes 0xFF then 0x81.
  - Without → 163: bytes 0xA3 then 0x80.
- Async reset mid-batch after 2 products → outputs at reset values; a fresh batch of len 1 with product 9 returns 0x09, 0x00.
